// File: rtl/adc_decimator.sv
// adc_decimator
//   Decimates the registered delta-ADC value by N = 2^LOG2_N. For each window of
//   N qualified samples it produces the floor mean, the minimum and the maximum.
//   Results leave on a valid/ready interface. A completed window that cannot be
//   delivered because a result is still waiting is dropped and latches overrun.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        synchronous active-low reset
//   en_i           1 = decimate, 0 = abort current window and idle
//   adc_value_i    ADC sample, qualified by sample_strb_i
//   sample_strb_i  single-cycle sample strobe
//   dec_data_o     window mean (sum >> LOG2_N, truncating)
//   dec_min_o      window minimum
//   dec_max_o      window maximum
//   dec_valid_o    result valid, held until accepted
//   dec_ready_i    consumer ready
//   overrun_o      sticky: a completed window was dropped
//   clr_overrun_i  clears overrun_o (a simultaneous drop wins)
//
// state  | meaning
// IDLE   | disabled, window registers held at their initial values
// ACCUM  | collecting samples into the current window

module adc_decimator #(
  parameter int W      = 16,
  parameter int LOG2_N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [W-1:0] adc_value_i,
  input  logic         sample_strb_i,
  output logic [W-1:0] dec_data_o,
  output logic [W-1:0] dec_min_o,
  output logic [W-1:0] dec_max_o,
  output logic         dec_valid_o,
  input  logic         dec_ready_i,
  output logic         overrun_o,
  input  logic         clr_overrun_i
);

  localparam int N  = 1 << LOG2_N;
  localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int AW = W + LOG2_N;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [0:0]    state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [W-1:0]  min_r;
  logic [W-1:0]  max_r;

  logic          count_en;
  logic          win_done;
  logic          load;
  logic          drop;
  logic [AW-1:0] sum_next;
  logic [AW-1:0] mean_full;
  logic [W-1:0]  min_next;
  logic [W-1:0]  max_next;

  always_comb begin
    count_en  = (state == S_ACCUM) && en_i && sample_strb_i;
    win_done  = count_en && (cnt == CNT_LAST);
    // A result slot is free if nothing is held or the held one leaves this cycle.
    load      = win_done && (!dec_valid_o || dec_ready_i);
    drop      = win_done && dec_valid_o && !dec_ready_i;
    sum_next  = acc + AW'(adc_value_i);
    mean_full = sum_next >> LOG2_N;
    min_next  = (adc_value_i < min_r) ? adc_value_i : min_r;
    max_next  = (adc_value_i > max_r) ? adc_value_i : max_r;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      min_r       <= '1;
      max_r       <= '0;
      dec_data_o  <= '0;
      dec_min_o   <= '0;
      dec_max_o   <= '0;
      dec_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en_i) state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (!en_i) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            min_r <= '1;
            max_r <= '0;
          end else if (count_en) begin
            // Completion reinitialises in place so the next strobe starts a new window.
            if (win_done) begin
              acc   <= '0;
              cnt   <= '0;
              min_r <= '1;
              max_r <= '0;
            end else begin
              acc   <= sum_next;
              cnt   <= cnt + CW'(1);
              min_r <= min_next;
              max_r <= max_next;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (load) begin
        dec_data_o  <= mean_full[W-1:0];
        dec_min_o   <= min_next;
        dec_max_o   <= max_next;
        dec_valid_o <= 1'b1;
      end else if (dec_valid_o && dec_ready_i) begin
        dec_valid_o <= 1'b0;
      end

      if (drop) overrun_o <= 1'b1;
      else if (clr_overrun_i) overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_decimator.sv
// Directed bench for adc_decimator: three instances (LOG2_N = 2, 4, 0) share
// the data/strobe/handshake inputs; each has its own enable.
module tb_adc_decimator;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en2, en4, en0;
  logic [W-1:0] adc_value;
  logic         strb;
  logic         ready;
  logic         clr;

  logic [W-1:0] data2, min2, max2, data4, min4, max4, data0, min0, max0;
  logic         valid2, ovr2, valid4, ovr4, valid0, ovr0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_decimator #(.W(W), .LOG2_N(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .en_i(en2), .adc_value_i(adc_value),
    .sample_strb_i(strb), .dec_data_o(data2), .dec_min_o(min2), .dec_max_o(max2),
    .dec_valid_o(valid2), .dec_ready_i(ready), .overrun_o(ovr2), .clr_overrun_i(clr)
  );

  adc_decimator #(.W(W), .LOG2_N(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .en_i(en4), .adc_value_i(adc_value),
    .sample_strb_i(strb), .dec_data_o(data4), .dec_min_o(min4), .dec_max_o(max4),
    .dec_valid_o(valid4), .dec_ready_i(ready), .overrun_o(ovr4), .clr_overrun_i(clr)
  );

  adc_decimator #(.W(W), .LOG2_N(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .en_i(en0), .adc_value_i(adc_value),
    .sample_strb_i(strb), .dec_data_o(data0), .dec_min_o(min0), .dec_max_o(max0),
    .dec_valid_o(valid0), .dec_ready_i(ready), .overrun_o(ovr0), .clr_overrun_i(clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [W-1:0] v);
    adc_value = v;
    strb      = 1'b1;
    tick();
    strb      = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; en2 = 1'b0; en4 = 1'b0; en0 = 1'b0;
    adc_value = '0; strb = 1'b0; ready = 1'b0; clr = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(valid2), 32'd0);
    check("rst_data",  32'(data2),  32'd0);
    check("rst_min",   32'(min2),   32'd0);
    check("rst_max",   32'(max2),   32'd0);
    check("rst_ovr",   32'(ovr2),   32'd0);
    reset_n = 1'b1;

    // 1: 10,20,30,41 -> mean 25
    ready = 1'b1; en2 = 1'b1;
    tick();
    strobe(16'd10); strobe(16'd20); strobe(16'd30);
    check("t1_not_yet", 32'(valid2), 32'd0);
    strobe(16'd41);
    check("t1_valid", 32'(valid2), 32'd1);
    check("t1_data",  32'(data2),  32'd25);
    check("t1_min",   32'(min2),   32'd10);
    check("t1_max",   32'(max2),   32'd41);
    tick();
    check("t1_valid_fall", 32'(valid2), 32'd0);

    // 3: ready low across two windows (means 5 then 9)
    ready = 1'b0;
    strobe(16'd4); strobe(16'd5); strobe(16'd6); strobe(16'd6);
    check("t3_valid", 32'(valid2), 32'd1);
    check("t3_data",  32'(data2),  32'd5);
    check("t3_ovr0",  32'(ovr2),   32'd0);
    strobe(16'd9); strobe(16'd9); strobe(16'd9); strobe(16'd9);
    check("t3_ovr1",      32'(ovr2),  32'd1);
    check("t3_data_hold", 32'(data2), 32'd5);
    check("t3_min_hold",  32'(min2),  32'd4);
    check("t3_max_hold",  32'(max2),  32'd6);
    ready = 1'b1;
    tick();
    check("t3_accept",      32'(valid2), 32'd0);
    check("t3_ovr_sticky",  32'(ovr2),   32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t3_ovr_clr", 32'(ovr2), 32'd0);

    // 4: abort after two samples, then a full window of 8s
    strobe(16'd100); strobe(16'd100);
    en2 = 1'b0;
    tick();
    check("t4_no_partial", 32'(valid2), 32'd0);
    en2 = 1'b1;
    tick();
    strobe(16'd8); strobe(16'd8); strobe(16'd8);
    check("t4_no_early", 32'(valid2), 32'd0);
    strobe(16'd8);
    check("t4_valid", 32'(valid2), 32'd1);
    check("t4_data",  32'(data2),  32'd8);
    check("t4_min",   32'(min2),   32'd8);
    check("t4_max",   32'(max2),   32'd8);
    tick();

    // 6: completion coincides with transfer of the previous result
    ready = 1'b0;
    strobe(16'd1); strobe(16'd1); strobe(16'd1); strobe(16'd1);
    check("t6_first", 32'(data2), 32'd1);
    strobe(16'd2); strobe(16'd2); strobe(16'd2);
    ready = 1'b1;
    strobe(16'd2);
    check("t6_valid", 32'(valid2), 32'd1);
    check("t6_data",  32'(data2),  32'd2);
    check("t6_ovr",   32'(ovr2),   32'd0);
    tick();
    check("t6_valid_fall", 32'(valid2), 32'd0);

    // 5: reset mid-window with a result pending
    ready = 1'b0;
    strobe(16'd7); strobe(16'd7); strobe(16'd7); strobe(16'd7);
    check("t5_pending", 32'(valid2), 32'd1);
    strobe(16'd50); strobe(16'd50); strobe(16'd50);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t5_valid", 32'(valid2),       32'd0);
    check("t5_data",  32'(data2),        32'd0);
    check("t5_min",   32'(min2),         32'd0);
    check("t5_max",   32'(max2),         32'd0);
    check("t5_ovr",   32'(ovr2),         32'd0);
    check("t5_state", 32'(u_dut2.state), 32'd0);
    // The strobe in the IDLE cycle must be ignored and the old partial window gone.
    ready = 1'b1;
    strobe(16'd12);
    strobe(16'd12); strobe(16'd12); strobe(16'd12);
    check("t5_idle_ignored", 32'(valid2), 32'd0);
    strobe(16'd16);
    check("t5_new_valid", 32'(valid2), 32'd1);
    check("t5_new_data",  32'(data2),  32'd13);
    check("t5_new_min",   32'(min2),   32'd12);
    check("t5_new_max",   32'(max2),   32'd16);
    tick();

    // 2: LOG2_N=4, sixteen full-scale samples
    en2 = 1'b0; en4 = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) strobe(16'hFFFF);
    check("t2_no_early", 32'(valid4), 32'd0);
    strobe(16'hFFFF);
    check("t2_valid", 32'(valid4), 32'd1);
    check("t2_data",  32'(data4),  32'h0000FFFF);
    check("t2_min",   32'(min4),   32'h0000FFFF);
    check("t2_max",   32'(max4),   32'h0000FFFF);
    tick();
    en4 = 1'b0;

    // LOG2_N=0: every counted strobe is a result
    en0 = 1'b1;
    tick();
    strobe(16'd1234);
    check("p0_valid", 32'(valid0), 32'd1);
    check("p0_data",  32'(data0),  32'd1234);
    check("p0_min",   32'(min0),   32'd1234);
    check("p0_max",   32'(max0),   32'd1234);
    strobe(16'd77);
    check("p0_data2", 32'(data0), 32'd77);
    tick();
    check("p0_valid_fall", 32'(valid0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
